uart_frame_tx: RTL

Parametrised multi-byte frame sender that serialises a wide parallel word into a sequence of bytes for the UART byte transmitter. It sits between the application logic and `uart_tx`, and generalises the fixed 40-byte sender with configurable payload length, byte order, an optional header byte and an optional checksum byte. It snapshots the payload at start, so the source may change mid-frame, and it supports abort.

---
 rtl/uart_frame_tx_if.sv | 24 ++
 rtl/uart_frame_tx.sv | 136 +++++++++++++
 2 files changed

// File: rtl/uart_frame_tx_if.sv
// Frame sender bus: application request side plus the UART byte handshake.
interface uart_frame_tx_if #(
   parameter int NBYTES = 40
);
   logic                send;
   logic [8*NBYTES-1:0] data;
   logic                abort;
   logic                busy;
   logic                done;
   logic                tx_start;
   logic [7:0]          tx_data;
   logic                tx_busy;
   logic                tx_done;

   modport master (
      output send, data, abort, tx_busy, tx_done,
      input  busy, done, tx_start, tx_data
   );

   modport slave (
      input  send, data, abort, tx_busy, tx_done,
      output busy, done, tx_start, tx_data
   );
endinterface

// File: rtl/uart_frame_tx.sv
// Multi-byte frame sender: snapshots a wide word and feeds it bytewise
// to a UART, with optional header/checksum bytes and abort.
module uart_frame_tx #(
   parameter int         NBYTES    = 40,
   parameter bit         MSB_FIRST = 1'b0,
   parameter bit         HDR_EN    = 1'b0,
   parameter logic [7:0] HEADER    = 8'hA5,
   parameter bit         CSUM_EN   = 1'b0
) (
   input logic            clk,
   input logic            rst,
   uart_frame_tx_if.slave bus
);
   localparam int L  = int'(HDR_EN) + NBYTES + int'(CSUM_EN);
   localparam int IW = $clog2(L + 1);
   localparam logic [IW-1:0] LAST = IW'(L - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [8*NBYTES-1:0] frame_q, frame_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [7:0]          sum_q, sum_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                tx_start_q, tx_start_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;

   logic       is_hdr;
   logic       is_csum;
   int         pos;
   int         pidx;
   logic [7:0] byte_sel;

   assign is_hdr  = HDR_EN && (idx_q == '0);
   assign is_csum = CSUM_EN && (idx_q == LAST);

   // Slot index to payload byte number, honouring byte order.
   always_comb begin
      pos      = int'(idx_q) - int'(HDR_EN);
      pidx     = MSB_FIRST ? (NBYTES - 1 - pos) : pos;
      byte_sel = '0;
      for (int b = 0; b < NBYTES; b++) begin
         if (b == pidx) byte_sel = frame_q[8*b +: 8];
      end
   end

   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      idx_d      = idx_q;
      sum_d      = sum_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      done_d     = 1'b0;
      if (bus.abort && (state_q != IDLE)) begin
         state_d = IDLE;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.send) begin
                  state_d = ISSUE;
                  frame_d = bus.data;
                  idx_d   = '0;
                  sum_d   = '0;
               end
            end
            ISSUE: begin
               if (!bus.tx_busy) begin
                  state_d    = WAIT;
                  tx_start_d = 1'b1;
                  if (is_hdr) begin
                     tx_data_d = HEADER;
                  end else if (is_csum) begin
                     tx_data_d = sum_q;
                  end else begin
                     tx_data_d = byte_sel;
                     sum_d     = sum_q + byte_sel;
                  end
               end
            end
            WAIT: begin
               if (bus.tx_done) begin
                  if (idx_q == LAST) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ISSUE;
                     idx_d   = idx_q + 1'b1;
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         frame_q    <= '0;
         idx_q      <= '0;
         sum_q      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         idx_q      <= idx_d;
         sum_q      <= sum_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
endmodule
